// File: rtl/fp_wire_pkg.sv
// rtl/fp_wire_pkg.sv - shared types and constants for the fp div/sqrt arbiter
package fp_wire;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } fp_arb_state_type;

    localparam logic [1:0]  FP_ARB_OP_DIV  = 2'b00;
    localparam logic [1:0]  FP_ARB_OP_SQRT = 2'b01;
    localparam logic [31:0] FP_QNAN32      = 32'h7FC00000;
    localparam logic [4:0]  FP_FLAG_NV     = 5'h10;

    // Any op code with the top bit set is not a div/sqrt operation.
    function automatic logic fp_arb_op_invalid(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/fp_rr_pick.sv
// rtl/fp_rr_pick.sv - combinational round-robin picker
module fp_rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic         any,
    output logic [W-1:0] idx
);

    // Scan from the slot after the pointer, wrapping, and take the first request.
    always_comb begin
        int pos;
        pos   = 0;
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = W'(pos);
            end
        end
    end

endmodule

// File: rtl/fp_divsqrt_arbiter.sv
// rtl/fp_divsqrt_arbiter.sv - round-robin sharing of one iterative div/sqrt unit
module fp_divsqrt_arbiter
    import fp_wire::*;
#(
    parameter int NREQ     = 4,
    parameter int MAX_WAIT = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [32*NREQ-1:0] req_data1,
    input  logic [32*NREQ-1:0] req_data2,
    input  logic [3*NREQ-1:0] req_rm,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [31:0]       resp_result,
    output logic [4:0]        resp_flags,
    output logic              resp_timeout,
    output logic              fpu_enable,
    output logic              fpu_fdiv,
    output logic              fpu_fsqrt,
    output logic [31:0]       fpu_data1,
    output logic [31:0]       fpu_data2,
    output logic [2:0]        fpu_rm,
    input  logic [31:0]       fpu_result,
    input  logic [4:0]        fpu_flags,
    input  logic              fpu_ready
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAX_WAIT);

    typedef struct packed {
        fp_arb_state_type state;
        logic [IDX_W-1:0] ptr;
        logic [IDX_W-1:0] owner;
        logic [1:0]       op;
        logic [31:0]      data1;
        logic [31:0]      data2;
        logic [2:0]       rm;
        logic [31:0]      result;
        logic [4:0]       flags;
        logic             timeout;
        logic             stale;
        logic [CNT_W-1:0] cnt;
    } reg_type;

    reg_type r;
    reg_type rin;

    logic [NREQ-1:0]  pick_grant;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    fp_rr_pick #(
        .N(NREQ),
        .W(IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (r.ptr),
        .grant (pick_grant),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    // Next-state and output decode; all outputs default to zero.
    always_comb begin
        rin          = r;
        req_ready    = '0;
        resp_valid   = '0;
        resp_result  = '0;
        resp_flags   = '0;
        resp_timeout = 1'b0;
        fpu_enable   = 1'b0;
        fpu_fdiv     = 1'b0;
        fpu_fsqrt    = 1'b0;
        fpu_data1    = '0;
        fpu_data2    = '0;
        fpu_rm       = '0;

        // The unit sees the latched operation only while it owns it.
        if (r.state == ISSUE || r.state == WAIT) begin
            fpu_fdiv  = (r.op == FP_ARB_OP_DIV);
            fpu_fsqrt = (r.op == FP_ARB_OP_SQRT);
            fpu_data1 = r.data1;
            fpu_data2 = r.data2;
            fpu_rm    = r.rm;
        end

        case (r.state)
            IDLE: begin
                // Gating on reset keeps req_ready low while reset is held.
                if (pick_any && !reset) begin
                    req_ready   = pick_grant;
                    rin.owner   = pick_idx;
                    rin.op      = req_op[2*pick_idx +: 2];
                    rin.data1   = req_data1[32*pick_idx +: 32];
                    rin.data2   = req_data2[32*pick_idx +: 32];
                    rin.rm      = req_rm[3*pick_idx +: 3];
                    rin.cnt     = '0;
                    rin.timeout = 1'b0;
                    if (fp_arb_op_invalid(req_op[2*pick_idx +: 2])) begin
                        rin.result = FP_QNAN32;
                        rin.flags  = FP_FLAG_NV;
                        rin.state  = RESP;
                    end else begin
                        rin.state  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                fpu_enable = 1'b1;
                rin.cnt    = '0;
                rin.state  = WAIT;
            end
            WAIT: begin
                if (fpu_ready) begin
                    rin.result = fpu_result;
                    rin.flags  = fpu_flags;
                    rin.state  = RESP;
                end else if (r.cnt == CNT_W'(MAX_WAIT - 1)) begin
                    // The unit is still busy; its eventual done pulse is drained later.
                    rin.result  = FP_QNAN32;
                    rin.flags   = FP_FLAG_NV;
                    rin.timeout = 1'b1;
                    rin.stale   = 1'b1;
                    rin.state   = RESP;
                end else begin
                    rin.cnt = r.cnt + 1'b1;
                end
            end
            RESP: begin
                resp_valid[r.owner] = 1'b1;
                resp_result         = r.result;
                resp_flags          = r.flags;
                resp_timeout        = r.timeout;
                if (resp_ready[r.owner]) begin
                    rin.ptr   = r.owner;
                    rin.state = r.stale ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (fpu_ready) begin
                    rin.stale = 1'b0;
                    rin.state = IDLE;
                end
            end
            default: begin
                rin.state = IDLE;
            end
        endcase
    end

    // State record register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r       <= '0;
            r.state <= IDLE;
            r.ptr   <= IDX_W'(NREQ - 1);
        end else begin
            r <= rin;
        end
    end

endmodule

// File: tb/tb_fp_divsqrt_arbiter.sv
// tb/tb_fp_divsqrt_arbiter.sv - directed self-checking bench for fp_divsqrt_arbiter
module tb_fp_divsqrt_arbiter;

    localparam int NREQ     = 4;
    localparam int MAX_WAIT = 64;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [7:0]   req_op;
    logic [127:0] req_data1;
    logic [127:0] req_data2;
    logic [11:0]  req_rm;
    logic [3:0]   resp_valid;
    logic [3:0]   resp_ready;
    logic [31:0]  resp_result;
    logic [4:0]   resp_flags;
    logic         resp_timeout;
    logic         fpu_enable;
    logic         fpu_fdiv;
    logic         fpu_fsqrt;
    logic [31:0]  fpu_data1;
    logic [31:0]  fpu_data2;
    logic [2:0]   fpu_rm;
    logic [31:0]  fpu_result;
    logic [4:0]   fpu_flags;
    logic         fpu_ready;

    int errors = 0;
    int checks = 0;

    // unit model state
    logic         stall = 1'b0;
    logic         busy = 1'b0;
    int           lat_cnt = 0;
    logic [31:0]  m_d1, m_d2;
    logic         m_sqrt;
    int           enable_count = 0;
    int           ready_count = 0;

    fp_divsqrt_arbiter #(
        .NREQ(NREQ),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data1(req_data1), .req_data2(req_data2), .req_rm(req_rm),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_flags(resp_flags), .resp_timeout(resp_timeout),
        .fpu_enable(fpu_enable), .fpu_fdiv(fpu_fdiv), .fpu_fsqrt(fpu_fsqrt),
        .fpu_data1(fpu_data1), .fpu_data2(fpu_data2), .fpu_rm(fpu_rm),
        .fpu_result(fpu_result), .fpu_flags(fpu_flags), .fpu_ready(fpu_ready)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Iterative unit model: done pulse 3 cycles after the start is seen, frozen while stalled.
    initial begin
        fpu_ready  = 1'b0;
        fpu_result = '0;
        fpu_flags  = '0;
        forever begin
            @(negedge clock);
            fpu_ready = 1'b0;
            if (reset) begin
                busy = 1'b0;
            end else begin
                if (busy && !stall) begin
                    if (lat_cnt == 0) begin
                        fpu_ready = 1'b1;
                        busy = 1'b0;
                        ready_count++;
                        if (m_sqrt && m_d1 == 32'h40800000) begin
                            fpu_result = 32'h40000000; fpu_flags = 5'h00;
                        end else if (!m_sqrt && m_d1 == 32'h3F800000 && m_d2 == 32'h40000000) begin
                            fpu_result = 32'h3F000000; fpu_flags = 5'h00;
                        end else if (!m_sqrt && m_d1 == 32'h3F800000 && m_d2 == 32'h40400000) begin
                            fpu_result = 32'h3EAAAAAB; fpu_flags = 5'h01;
                        end else begin
                            fpu_result = 32'h0; fpu_flags = 5'h00;
                        end
                    end else begin
                        lat_cnt--;
                    end
                end
                if (fpu_enable) begin
                    busy = 1'b1;
                    lat_cnt = 2;
                    m_d1 = fpu_data1;
                    m_d2 = fpu_data2;
                    m_sqrt = fpu_fsqrt;
                    enable_count++;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [2:0] rm);
        req_op[2*i +: 2]     = op;
        req_data1[32*i +: 32] = d1;
        req_data2[32*i +: 32] = d2;
        req_rm[3*i +: 3]     = rm;
        req_valid[i]         = 1'b1;
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_resp(input int maxc, output int cyc);
        cyc = 0;
        while (resp_valid == 4'b0 && cyc < maxc) begin
            tick();
            cyc++;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_valid = '0;
        resp_ready = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'b1111;
        resp_ready = '0;
        req_op = '0; req_data1 = '0; req_data2 = '0; req_rm = '0;
        tick();
        tick();
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0000", resp_valid); end
        checks++; if ({fpu_enable, fpu_fdiv, fpu_fsqrt, fpu_data1, fpu_data2, fpu_rm} !== '0) begin errors++; $display("FAIL reset_fpu_out: enable=%b data1=%h want all 0", fpu_enable, fpu_data1); end
        checks++; if ({resp_result, resp_flags, resp_timeout} !== '0) begin errors++; $display("FAIL reset_resp_out: result=%h flags=%h want 0", resp_result, resp_flags); end
        req_valid = '0;
        reset = 1'b0;
    endtask

    task automatic test_div();
        int cyc;
        tick();
        set_req(0, 2'b00, 32'h3F800000, 32'h40000000, 3'd0);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL div_grant: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        checks++; if ({fpu_enable, fpu_fdiv, fpu_fsqrt} !== 3'b110) begin errors++; $display("FAIL div_issue: en/div/sqrt got %b want 110", {fpu_enable, fpu_fdiv, fpu_fsqrt}); end
        checks++; if ({fpu_data1, fpu_data2, fpu_rm} !== {32'h3F800000, 32'h40000000, 3'd0}) begin errors++; $display("FAIL div_operands: got %h %h %h", fpu_data1, fpu_data2, fpu_rm); end
        repeat (3) tick();
        checks++; if ({fpu_ready, resp_valid} !== 5'b1_0000) begin errors++; $display("FAIL div_latency_pre: ready=%b resp_valid=%b want 1 0000", fpu_ready, resp_valid); end
        tick();
        checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL div_resp_valid: got %b want 0001", resp_valid); end
        checks++; if ({resp_result, resp_flags, resp_timeout} !== {32'h3F000000, 5'h00, 1'b0}) begin errors++; $display("FAIL div_result: got %h/%h/%b want 3f000000/00/0", resp_result, resp_flags, resp_timeout); end
        resp_ready[0] = 1'b1;
        tick();
        resp_ready = '0;
        checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL div_resp_done: got %b want 0000", resp_valid); end
        wait_resp(0, cyc);
    endtask

    task automatic test_sqrt();
        int cyc, en0;
        en0 = enable_count;
        set_req(2, 2'b01, 32'h40800000, 32'h0, 3'd1);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL sqrt_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        checks++; if ({fpu_enable, fpu_fdiv, fpu_fsqrt, fpu_rm} !== 6'b101_001) begin errors++; $display("FAIL sqrt_issue: got %b want 101001", {fpu_enable, fpu_fdiv, fpu_fsqrt, fpu_rm}); end
        wait_resp(20, cyc);
        checks++; if (enable_count - en0 !== 1) begin errors++; $display("FAIL sqrt_enable_cycles: got %0d want 1", enable_count - en0); end
        checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL sqrt_resp_valid: got %b want 0100", resp_valid); end
        checks++; if ({resp_result, resp_flags} !== {32'h40000000, 5'h00}) begin errors++; $display("FAIL sqrt_result: got %h/%h want 40000000/00", resp_result, resp_flags); end
        resp_ready[2] = 1'b1;
        tick();
        resp_ready = '0;
    endtask

    task automatic test_fairness();
        int cyc;
        logic [3:0] want;
        apply_reset();
        for (int i = 0; i < 4; i++) set_req(i, 2'b00, 32'h3F800000, 32'h40400000, 3'd0);
        resp_ready = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_resp(20, cyc);
            want = 4'(1 << (n % 4));
            checks++; if (resp_valid !== want) begin errors++; $display("FAIL fair_order_%0d: got %b want %b", n, resp_valid, want); end
            checks++; if ({resp_result, resp_flags} !== {32'h3EAAAAAB, 5'h01}) begin errors++; $display("FAIL fair_result_%0d: got %h/%h want 3eaaaaab/01", n, resp_result, resp_flags); end
            if (n == 4) req_valid = '0;
            tick();
        end
        resp_ready = '0;
    endtask

    task automatic test_backpressure();
        int cyc;
        set_req(1, 2'b00, 32'h3F800000, 32'h40000000, 3'd0);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        set_req(2, 2'b00, 32'h3F800000, 32'h40000000, 3'd0);
        set_req(3, 2'b00, 32'h3F800000, 32'h40000000, 3'd0);
        wait_resp(20, cyc);
        for (int k = 0; k < 5; k++) begin
            checks++; if ({resp_valid, resp_result, resp_flags, resp_timeout} !== {4'b0010, 32'h3F000000, 5'h00, 1'b0}) begin errors++; $display("FAIL bp_hold_%0d: valid=%b result=%h flags=%h", k, resp_valid, resp_result, resp_flags); end
            checks++; if ({req_ready, fpu_enable} !== 5'b0) begin errors++; $display("FAIL bp_idle_%0d: req_ready=%b enable=%b want 0", k, req_ready, fpu_enable); end
            tick();
        end
        req_valid = '0;
        resp_ready[1] = 1'b1;
        tick();
        resp_ready = '0;
        checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL bp_release: got %b want 0000", resp_valid); end
    endtask

    task automatic test_timeout();
        int cyc, en0, r0;
        stall = 1'b1;
        set_req(3, 2'b00, 32'h3F800000, 32'h40400000, 3'd0);
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL to_grant: got %b want 1000", req_ready); end
        tick();
        req_valid = '0;
        set_req(0, 2'b00, 32'h3F800000, 32'h40000000, 3'd0);
        wait_resp(100, cyc);
        checks++; if (cyc !== 65) begin errors++; $display("FAIL to_cycles: got %0d want 65", cyc); end
        checks++; if ({resp_valid, resp_result, resp_flags, resp_timeout} !== {4'b1000, 32'h7FC00000, 5'h10, 1'b1}) begin errors++; $display("FAIL to_resp: valid=%b result=%h flags=%h to=%b", resp_valid, resp_result, resp_flags, resp_timeout); end
        resp_ready[3] = 1'b1;
        tick();
        resp_ready = '0;
        en0 = enable_count;
        r0 = ready_count;
        for (int k = 0; k < 3; k++) begin
            checks++; if ({req_ready, fpu_enable} !== 5'b0) begin errors++; $display("FAIL to_drain_%0d: req_ready=%b enable=%b want 0", k, req_ready, fpu_enable); end
            tick();
        end
        stall = 1'b0;
        cyc = 0;
        while (!fpu_enable && cyc < 20) begin tick(); cyc++; end
        checks++; if ({fpu_enable, fpu_data2} !== {1'b1, 32'h40000000}) begin errors++; $display("FAIL to_next_enable: enable=%b data2=%h", fpu_enable, fpu_data2); end
        checks++; if (ready_count - r0 !== 1 || enable_count !== en0 + 1) begin errors++; $display("FAIL to_drain_order: late_ready=%0d enables=%0d want 1 1", ready_count - r0, enable_count - en0); end
        req_valid = '0;
        wait_resp(20, cyc);
        checks++; if ({resp_valid, resp_result, resp_timeout} !== {4'b0001, 32'h3F000000, 1'b0}) begin errors++; $display("FAIL to_after: valid=%b result=%h to=%b", resp_valid, resp_result, resp_timeout); end
        resp_ready[0] = 1'b1;
        tick();
        resp_ready = '0;
    endtask

    task automatic test_reset_mid_wait();
        int cyc;
        stall = 1'b1;
        set_req(1, 2'b00, 32'h3F800000, 32'h40000000, 3'd0);
        tick();
        tick();
        checks++; if ({fpu_fdiv, fpu_data1} !== {1'b1, 32'h3F800000}) begin errors++; $display("FAIL rst_wait_pre: div=%b data1=%h", fpu_fdiv, fpu_data1); end
        reset = 1'b1;
        tick();
        checks++; if ({req_ready, resp_valid, fpu_enable, fpu_fdiv, fpu_data1} !== '0) begin errors++; $display("FAIL rst_wait_out: ready=%b valid=%b div=%b data1=%h want 0", req_ready, resp_valid, fpu_fdiv, fpu_data1); end
        tick();
        reset = 1'b0;
        stall = 1'b0;
        req_valid = '0;
        set_req(0, 2'b00, 32'h3F800000, 32'h40000000, 3'd0);
        set_req(1, 2'b00, 32'h3F800000, 32'h40000000, 3'd0);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_wait_grant: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        wait_resp(20, cyc);
        checks++; if ({resp_valid, resp_result} !== {4'b0001, 32'h3F000000}) begin errors++; $display("FAIL rst_wait_resp: valid=%b result=%h", resp_valid, resp_result); end
        resp_ready[0] = 1'b1;
        tick();
        resp_ready = '0;
    endtask

    task automatic test_invalid_op();
        int en0;
        en0 = enable_count;
        set_req(2, 2'b10, 32'h3F800000, 32'h40000000, 3'd0);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL inv_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        checks++; if ({resp_valid, resp_result, resp_flags, resp_timeout, fpu_enable} !== {4'b0100, 32'h7FC00000, 5'h10, 1'b0, 1'b0}) begin errors++; $display("FAIL inv_resp: valid=%b result=%h flags=%h to=%b en=%b", resp_valid, resp_result, resp_flags, resp_timeout, fpu_enable); end
        resp_ready[2] = 1'b1;
        tick();
        resp_ready = '0;
        repeat (2) tick();
        checks++; if (enable_count !== en0) begin errors++; $display("FAIL inv_no_enable: got %0d enables want 0", enable_count - en0); end
    endtask

    initial begin
        test_reset();
        test_div();
        test_sqrt();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        test_invalid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
